// File: rtl/dma_timing_ctrl_pkg.sv
// Shared types, constants and state helpers for the DMA channel timing controller.
package dma_timing_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [1:0] XFER_ILLEGAL = 2'b11;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5
  } dma_state_t;

  typedef enum logic [1:0] {
    VERIFY = 2'b00,
    WRITE  = 2'b01,
    READ   = 2'b10
  } xfer_t;

  typedef enum logic [1:0] {
    DEMAND = 2'b00,
    SINGLE = 2'b01,
    BLOCK  = 2'b10
  } op_mode_t;

  // Registered output payload; strobes and eop are active-low levels.
  typedef struct packed {
    logic hrq;
    logic dack;
    logic aen;
    logic adstb;
    logic ior;
    logic iow;
    logic memr;
    logic memw;
    logic eop;
    logic tc;
    logic addr_step;
    logic reload;
    logic mask_set;
    logic idle_cycle;
    logic active_cycle;
  } dma_out_t;

  localparam dma_out_t DMA_OUT_RESET = '{
    hrq:          1'b0,
    dack:         1'b0,
    aen:          1'b0,
    adstb:        1'b0,
    ior:          1'b1,
    iow:          1'b1,
    memr:         1'b1,
    memw:         1'b1,
    eop:          1'b1,
    tc:           1'b0,
    addr_step:    1'b0,
    reload:       1'b0,
    mask_set:     1'b0,
    idle_cycle:   1'b1,
    active_cycle: 1'b0
  };

  function automatic logic is_active(input dma_state_t s);
    return (s == S1) || (s == S2) || (s == S3) || (s == S4);
  endfunction

  function automatic logic is_idle(input dma_state_t s);
    return s == SI;
  endfunction

endpackage

// File: rtl/dma_timing_ctrl_if.sv
// Request/strobe bundle between the channel timing controller and its surroundings.
interface dma_timing_ctrl_if #(
  parameter int unsigned CNT_W = dma_timing_ctrl_pkg::CNT_W_DEF
);
  import dma_timing_ctrl_pkg::*;

  logic             dreq;
  logic             hlda;
  logic             ready;
  logic             eop_in_n;
  logic [1:0]       xfer_type;
  logic [1:0]       op_mode;
  logic             autoinit;
  logic [CNT_W-1:0] cur_count;
  logic             addr_hi_change;

  logic             hrq;
  logic             dack;
  logic             aen;
  logic             adstb;
  logic             ior;
  logic             iow;
  logic             memr;
  logic             memw;
  logic             eop;
  logic             tc;
  logic             addr_step;
  logic             reload;
  logic             mask_set;
  logic             idle_cycle;
  logic             active_cycle;
  dma_state_t       state;

  // Controller side
  modport slave (
    input  dreq, hlda, ready, eop_in_n, xfer_type, op_mode, autoinit,
           cur_count, addr_hi_change,
    output hrq, dack, aen, adstb, ior, iow, memr, memw, eop, tc,
           addr_step, reload, mask_set, idle_cycle, active_cycle, state
  );

  // Environment side (priority logic, CPU, register block, datapath)
  modport master (
    output dreq, hlda, ready, eop_in_n, xfer_type, op_mode, autoinit,
           cur_count, addr_hi_change,
    input  hrq, dack, aen, adstb, ior, iow, memr, memw, eop, tc,
           addr_step, reload, mask_set, idle_cycle, active_cycle, state
  );

endinterface

// File: rtl/dma_timing_ctrl.sv
// 8237A-style single-channel transfer timing FSM (SI, S0..S4). Every output is
// decoded from the next state and registered, so strobe edges line up with state entry.
module dma_timing_ctrl
  import dma_timing_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  dma_timing_ctrl_if.slave bus
);

  dma_state_t state_q, state_d;
  dma_out_t   out_q, out_d;
  logic       eop_ext_q, eop_ext_d;

  logic       xfer_legal;
  logic       mode_legal;
  logic       is_read;
  logic       is_write;
  logic       term;
  dma_state_t next_xfer;

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    eop_ext_d = eop_ext_q;
    out_d     = DMA_OUT_RESET;

    xfer_legal = (bus.xfer_type != XFER_ILLEGAL);
    mode_legal = (bus.op_mode != MODE_ILLEGAL);
    is_read    = (bus.xfer_type == READ);
    is_write   = (bus.xfer_type == WRITE);
    // An EOP pin sample taken in this S4 terminates alongside an earlier latched one.
    term       = out_q.tc | eop_ext_q | ~bus.eop_in_n;
    next_xfer  = bus.addr_hi_change ? S1 : S2;

    case (state_q)
      SI: begin
        if (bus.dreq && xfer_legal && mode_legal) state_d = S0;
      end
      S0: begin
        if (bus.hlda) begin
          state_d = S1;
        end else if (!bus.dreq && (bus.op_mode != BLOCK)) begin
          state_d = SI;
        end
      end
      S1: state_d = S2;
      S2: state_d = S3;
      S3: begin
        if (bus.ready) state_d = S4;
      end
      S4: begin
        if (term) begin
          state_d        = SI;
          out_d.reload   = bus.autoinit;
          out_d.mask_set = ~bus.autoinit;
        end else if (bus.op_mode == BLOCK) begin
          state_d = next_xfer;
        end else if ((bus.op_mode == DEMAND) && bus.dreq) begin
          state_d = next_xfer;
        end else begin
          state_d = SI;
        end
      end
      default: state_d = SI;
    endcase

    out_d.hrq          = (state_d != SI);
    out_d.dack         = is_active(state_d);
    out_d.aen          = is_active(state_d);
    out_d.adstb        = (state_d == S1);
    out_d.memr         = ~(is_read  && ((state_d == S2) || (state_d == S3)));
    out_d.ior          = ~(is_write && ((state_d == S2) || (state_d == S3)));
    out_d.iow          = ~(is_read  && (state_d == S3));
    out_d.memw         = ~(is_write && (state_d == S3));
    out_d.addr_step    = (state_d == S4);
    out_d.tc           = (state_d == S4) && (bus.cur_count == CNT_W'(0));
    out_d.eop          = ~out_d.tc;
    out_d.idle_cycle   = is_idle(state_d);
    out_d.active_cycle = is_active(state_d);

    // External EOP latch: set by any low sample during S1..S4, cleared entering SI
    if (state_d == SI) begin
      eop_ext_d = 1'b0;
    end else if (is_active(state_q) && !bus.eop_in_n) begin
      eop_ext_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= SI;
      out_q     <= DMA_OUT_RESET;
      eop_ext_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      eop_ext_q <= eop_ext_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.hrq          = out_q.hrq;
  assign bus.dack         = out_q.dack;
  assign bus.aen          = out_q.aen;
  assign bus.adstb        = out_q.adstb;
  assign bus.ior          = out_q.ior;
  assign bus.iow          = out_q.iow;
  assign bus.memr         = out_q.memr;
  assign bus.memw         = out_q.memw;
  assign bus.eop          = out_q.eop;
  assign bus.tc           = out_q.tc;
  assign bus.addr_step    = out_q.addr_step;
  assign bus.reload       = out_q.reload;
  assign bus.mask_set     = out_q.mask_set;
  assign bus.idle_cycle   = out_q.idle_cycle;
  assign bus.active_cycle = out_q.active_cycle;

endmodule

// File: doc/dma_timing_ctrl.md
Name: dma_timing_ctrl

Overview:
- Transfer timing state machine for one 8237A-style DMA channel (SI, S0, S1, S2, S3, S4).
- Sits directly upstream of the DMA datapath. Drives the active-low strobe levels that the datapath gates onto IOR_N, IOW_N, MEMR_N, MEMW_N and EOP_N, plus AEN/ADSTB and the IDLE/ACTIVE cycle qualifiers.
- Also tells the channel register block when to step the address/count, autoinitialize, or set the channel mask.

Parameters:
- CNT_W, 16, width of the current word count input.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET_N  input  1  asynchronous active-low reset.
- dreq  input  1  resolved, priority-winning channel request (active-high).
- hlda  input  1  hold acknowledge from the CPU.
- ready  input  1  slow-device ready, sampled in S3.
- eop_in_n  input  1  external EOP_N as read back from the pin (active-low).
- xfer_type  input  2  00 verify, 01 write (I/O to mem), 10 read (mem to I/O), 11 illegal.
- op_mode  input  2  00 demand, 01 single, 10 block, 11 illegal.
- autoinit  input  1  reload base registers at terminal count.
- cur_count  input  CNT_W  current word count from the register block.
- addr_hi_change  input  1  upper address byte differs from the last one strobed.
- hrq  output  1  hold request to the CPU.
- dack  output  1  DMA acknowledge (active-high).
- aen, adstb  output  1 each  address enable and upper-address strobe.
- ior, iow, memr, memw  output  1 each  active-low strobe levels.
- eop  output  1  active-low internal EOP drive.
- tc  output  1  terminal-count pulse.
- addr_step  output  1  one-cycle pulse: step address, decrement count.
- reload  output  1  one-cycle autoinit pulse.
- mask_set  output  1  one-cycle pulse: set this channel's mask bit.
- idle_cycle, active_cycle  output  1 each  program (SI) vs. DMA (S1..S4) qualifiers.
- state  output  3  current state (dma_state_t), for debug and coverage.

Behaviour:
- Reset (async, RESET_N=0):
  - state=SI.
  - hrq, dack, aen, adstb, tc, addr_step, reload, mask_set = 0.
  - ior, iow, memr, memw, eop = 1.
  - idle_cycle=1, active_cycle=0.
  - Reset mid-transfer aborts immediately; there is no deferred completion.
- SI:
  - idle_cycle=1.
  - If dreq=1 and xfer_type and op_mode are both legal -> S0, with hrq=1 from the next cycle.
  - Illegal modes never leave SI.
- S0:
  - hrq held.
  - hlda=1 -> S1.
  - dreq=0 before hlda, in demand or single mode -> SI with hrq=0.
- S1:
  - aen=1, adstb=1, dack=1 -> S2.
  - Entered on the first transfer, and afterwards only when addr_hi_change=1.
- S2:
  - adstb=0.
  - Read transfer: memr=0.
  - Write transfer: ior=0.
  - Verify: no strobes.
  - -> S3.
- S3:
  - Read transfer: iow=0.
  - Write transfer: memw=0.
  - S2 strobes are held.
  - ready=0: stay in S3 (wait state), holding all strobes, unbounded.
  - ready=1: -> S4.
- S4:
  - All read/write strobes return to 1.
  - addr_step=1.
  - tc=1 if cur_count==0 (count is about to wrap to all-ones).
  - eop=0 during S4 if tc.
- Termination = tc, or a latched external EOP.
- External EOP latch:
  - eop_in_n is sampled every cycle in S1..S4; a 0 sets the latch.
  - The current transfer always completes through S4; the latch clears on entry to SI.
  - tc and external EOP in the same S4 produce a single termination.
- Exit from S4:
  - On termination:
    - autoinit=1 -> reload=1.
    - Otherwise -> mask_set=1.
    - Then -> SI with hrq=0, dack=0, aen=0.
  - Otherwise, by op_mode:
    - single -> SI (hrq released each transfer).
    - block -> S1 if addr_hi_change, else S2.
    - demand -> S1/S2 by the same rule if dreq=1, else SI.
- Control strobes and status:
  - dreq dropping during S1..S3 does not abort the transfer.
  - aen and dack stay 1 from S1 until SI re-entry.
  - active_cycle=1 in S1..S4.
  - All outputs are registered from the next state; strobe edges align with the posedge entering each state.
  - addr_step, reload, mask_set and tc are exactly one cycle wide.

Decomposition:
- DmaPackage:
  - dma_state_t enum {SI,S0,S1,S2,S3,S4}.
  - xfer_t enum {VERIFY,WRITE,READ}.
  - op_mode_t enum {DEMAND,SINGLE,BLOCK}.
  - CNT_W default constant.
  - isActive()/isIdle() state helper functions.
- No sub-module. Next-state logic and the output decode live in one always_comb; the registers and the EOP latch live in always_ff.

Test Plan:
- Single read, count=2, ready=1, addr_hi_change=1 first time:
  - Sequence SI,S0,S1,S2,S3,S4,SI.
  - memr low in S2–S3, iow low in S3 only.
  - addr_step 1 pulse; tc=0; hrq drops after S4.
- Block write, count=1, addr_hi_change=0 after the first transfer:
  - Second transfer skips S1 (S4->S2).
  - Second S4: tc=1, eop=0; mask_set pulses with autoinit=0.
  - Returns to SI.
- Wait states: read transfer, ready=0 for 3 cycles in S3:
  - S3 held 4 cycles, memr and iow held low.
  - addr_step fires once.
- External EOP: eop_in_n pulsed low in S2 of the first transfer of a block of count=5:
  - Transfer completes through S4.
  - Terminates to SI; tc=0; mask_set=1.
- Autoinit with simultaneous termination: tc and eop_in_n low in the same S4 with autoinit=1:
  - Exactly one reload pulse, no mask_set.
- Async reset asserted mid-S3:
  - All strobes=1, hrq=0, state=SI immediately, with no CLK edge needed.
  - Illegal xfer_type=11 with dreq=1 stays in SI.
